// File: rtl/data_parity_merger.sv
// data_parity_merger: merges the even-parity and odd-parity AXI-Stream byte
// channels into one AXI-Stream master using packet-aware round-robin
// arbitration. Every forwarded byte is re-checked against the parity class
// of the channel it came from; tuser flags a mismatch and err_count
// saturates.
// Optional macro DATA_PARITY_MERGE_DROP_EN: mismatched beats without tlast
// are consumed but not forwarded.
// Note: axis_aresetn is a synchronous, active-high reset.
module data_parity_merger #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PKT_LEN   = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     a_clk,
  input  logic                     axis_aresetn,
  input  logic                     axis_s_tvalid_even,
  input  logic [DATA_WIDTH-1:0]    axis_s_tdata_even,
  input  logic                     axis_s_tlast_even,
  output logic                     axis_s_tready_even,
  input  logic                     axis_s_tvalid_odd,
  input  logic [DATA_WIDTH-1:0]    axis_s_tdata_odd,
  input  logic                     axis_s_tlast_odd,
  output logic                     axis_s_tready_odd,
  output logic                     axis_m_tvalid,
  output logic [DATA_WIDTH-1:0]    axis_m_tdata,
  output logic                     axis_m_tlast,
  output logic                     axis_m_tuser,
  input  logic                     axis_m_tready,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, GRANT_EVEN, GRANT_ODD} state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;   // 1 = odd channel
  logic [7:0]      beat_cnt, beat_cnt_nxt;

  logic                  out_free;
  logic                  sel_odd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  accept;
  logic                  mismatch;
  logic [7:0]            cnt_inc;
  logic                  pkt_end;
  logic                  drop;
  logic                  fwd;

  // The output slice can take a new beat when empty or draining this cycle.
  assign out_free = !axis_m_tvalid || axis_m_tready;

  assign axis_s_tready_even = (state == GRANT_EVEN) && out_free;
  assign axis_s_tready_odd  = (state == GRANT_ODD)  && out_free;

  assign sel_odd  = (state == GRANT_ODD);
  assign sel_data = sel_odd ? axis_s_tdata_odd : axis_s_tdata_even;
  assign sel_last = sel_odd ? axis_s_tlast_odd : axis_s_tlast_even;

  assign accept = (axis_s_tvalid_even && axis_s_tready_even) ||
                  (axis_s_tvalid_odd  && axis_s_tready_odd);

  // Even channel must carry parity 0, odd channel parity 1.
  assign mismatch = (^sel_data) ^ sel_odd;

  assign cnt_inc = beat_cnt + 8'd1;
  assign pkt_end = sel_last || (cnt_inc == 8'(MAX_PKT_LEN));

`ifdef DATA_PARITY_MERGE_DROP_EN
  // A bad beat carrying tlast is still forwarded so framing survives.
  assign drop = mismatch && !sel_last;
`else
  assign drop = 1'b0;
`endif

  assign fwd = accept && !drop;

  // Next-state: arbitrate in IDLE, hold the grant until the packet ends.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (axis_s_tvalid_even && axis_s_tvalid_odd)
          state_nxt = last_grant ? GRANT_EVEN : GRANT_ODD;
        else if (axis_s_tvalid_even)
          state_nxt = GRANT_EVEN;
        else if (axis_s_tvalid_odd)
          state_nxt = GRANT_ODD;
      end
      GRANT_EVEN, GRANT_ODD: begin
        if (fwd) begin
          if (pkt_end) begin
            state_nxt      = IDLE;
            beat_cnt_nxt   = 8'd0;
            last_grant_nxt = sel_odd;
          end else begin
            beat_cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge a_clk) begin
    if (axis_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Output register slice; a held beat is discarded on reset.
  always_ff @(posedge a_clk) begin
    if (axis_aresetn) begin
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tlast  <= 1'b0;
      axis_m_tuser  <= 1'b0;
    end else if (fwd) begin
      axis_m_tvalid <= 1'b1;
      axis_m_tdata  <= sel_data;
      axis_m_tlast  <= pkt_end;
      axis_m_tuser  <= mismatch;
    end else if (axis_m_tready) begin
      axis_m_tvalid <= 1'b0;
    end
  end

  // Saturating count of accepted beats with the wrong parity class.
  always_ff @(posedge a_clk) begin
    if (axis_aresetn)
      err_count <= '0;
    else if (accept && mismatch && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_data_parity_merger.sv
// Self-checking bench for data_parity_merger: directed scenarios plus
// randomized packet streams compared with a packet-level reference model.
module tb_data_parity_merger;

  localparam int DW   = 8;
  localparam int MAXP = 8;
  localparam int EW   = 8;
  localparam int ERR_MAX = (1 << EW) - 1;
`ifdef DATA_PARITY_MERGE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic [7:0] d; logic l; logic u;} out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ve = 1'b0, le = 1'b0, vo = 1'b0, lo = 1'b0;
  logic [DW-1:0] de = '0, dodd = '0;
  logic          tready_even, tready_odd;
  logic          m_tvalid, m_tlast, m_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tready = 1'b0;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  beat_t qe[$];
  beat_t qo[$];
  out_t  exp_q[$];

  always #5 clk = ~clk;

  data_parity_merger #(.DATA_WIDTH(DW), .MAX_PKT_LEN(MAXP), .ERR_CNT_WIDTH(EW)) dut (
    .a_clk(clk), .axis_aresetn(rst),
    .axis_s_tvalid_even(ve), .axis_s_tdata_even(de), .axis_s_tlast_even(le),
    .axis_s_tready_even(tready_even),
    .axis_s_tvalid_odd(vo), .axis_s_tdata_odd(dodd), .axis_s_tlast_odd(lo),
    .axis_s_tready_odd(tready_odd),
    .axis_m_tvalid(m_tvalid), .axis_m_tdata(m_tdata), .axis_m_tlast(m_tlast),
    .axis_m_tuser(m_tuser), .axis_m_tready(m_tready), .err_count(err_count)
  );

  // Reference: alternate whole packets between channels (even first after
  // reset), cut packets at MAXP beats, flag beats whose parity disagrees
  // with their channel. A channel running dry mid-packet keeps the grant.
  function automatic void build_model();
    beat_t e[$];
    beat_t o[$];
    beat_t b;
    bit last, ch, mism, done;
    int n;
    e = qe; o = qo; last = 1'b1;
    while (e.size() != 0 || o.size() != 0) begin
      if (e.size() != 0 && o.size() != 0) ch = !last;
      else ch = (o.size() != 0);
      n = 0; done = 1'b0;
      while (!done) begin
        if ((ch ? o.size() : e.size()) == 0) return;
        b = ch ? o.pop_front() : e.pop_front();
        mism = (^b.d) ^ ch;
        if (mism && exp_err < ERR_MAX) exp_err++;
        if (!(DROP && mism && !b.l)) begin
          n++;
          exp_q.push_back('{d: b.d, l: (b.l || n == MAXP), u: mism});
          done = b.l || n == MAXP;
        end
      end
      last = ch;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; ve = 0; vo = 0; le = 0; lo = 0; de = '0; dodd = '0; m_tready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 0;
    qe.delete(); qo.delete(); exp_q.delete();
  endtask

  // Drive qe/qo continuously, check every output transfer against the model.
  task automatic run_stream(input string name, input int budget, input bit rand_ready);
    int cyc;
    cyc = 0;
    build_model();
    while ((qe.size() != 0 || qo.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      ve = (qe.size() != 0); de = ve ? qe[0].d : '0; le = ve ? qe[0].l : 1'b0;
      vo = (qo.size() != 0); dodd = vo ? qo[0].d : '0; lo = vo ? qo[0].l : 1'b0;
      m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      checks++;
      if (tready_even && tready_odd) begin
        errors++;
        $display("FAIL %s_ready_excl: both readies 1, required at most one", name);
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got beat %h, required no beat", name, m_tdata);
        end else begin : cmp
          out_t e;
          e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_tuser} !== {e.d, e.l, e.u}) begin
            errors++;
            $display("FAIL %s_beat: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                     name, m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
          end
        end
      end
      if (ve && tready_even) void'(qe.pop_front());
      if (vo && tready_odd)  void'(qo.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    ve = 0; vo = 0; m_tready = 1'b1;
    checks++;
    if (qe.size() != 0 || qo.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: left even=%0d odd=%0d out=%0d, required all 0",
               name, qe.size(), qo.size(), exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (err_count !== EW'(exp_err)) begin
      errors++;
      $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, exp_err);
    end
    qe.delete(); qo.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, err_count, tready_even, tready_odd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b u=%b e=%h re=%b ro=%b, required all 0",
               m_tvalid, m_tdata, m_tlast, m_tuser, err_count, tready_even, tready_odd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int cyc;
    bit fired;
    do_reset();
    m_tready = 1; ve = 1; de = 8'h03; le = 1;
    cyc = 0; fired = 0;
    while (!fired && cyc < 10) begin
      @(negedge clk);
      fired = ve && tready_even;
      checks++;
      if (m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early: got tvalid=%b before acceptance, required 0", m_tvalid);
      end
      @(posedge clk); #1; cyc++;
    end
    ve = 0; le = 0;
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL latency_accept: got no acceptance in 10 cycles, required one");
    end
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== {1'b1, 8'h03, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL latency_beat: got v=%b d=%h l=%b u=%b, required v=1 d=03 l=1 u=0",
               m_tvalid, m_tdata, m_tlast, m_tuser);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    do_reset();
    qe.push_back('{d: 8'h03, l: 1'b0}); qe.push_back('{d: 8'h05, l: 1'b0});
    qe.push_back('{d: 8'h06, l: 1'b1});
    qo.push_back('{d: 8'h01, l: 1'b0}); qo.push_back('{d: 8'h02, l: 1'b0});
    qo.push_back('{d: 8'h07, l: 1'b1});
    run_stream("arb", 40, 1'b0);
  endtask

  task automatic test_forced_tlast();
    do_reset();
    for (int i = 0; i < 12; i++) qe.push_back('{d: 8'h03, l: (i == 11)});
    for (int i = 0; i < 10; i++) qo.push_back('{d: 8'h01, l: 1'b0});
    run_stream("forced", 100, 1'b0);
  endtask

  task automatic test_parity_err();
    do_reset();
    qe.push_back('{d: 8'h01, l: 1'b1});
    run_stream("par_one", 20, 1'b0);
    for (int i = 0; i < 256; i++) qe.push_back('{d: 8'h01, l: (i % 4 == 3)});
    run_stream("par_sat", 3000, 1'b1);
  endtask

  task automatic test_hold();
    int cyc;
    bit fired;
    do_reset();
    m_tready = 0; ve = 1; de = 8'h0F; le = 1;
    cyc = 0; fired = 0;
    while (!fired && cyc < 10) begin
      @(negedge clk); fired = ve && tready_even;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL hold_accept: got no acceptance in 10 cycles, required one");
    end
    de = 8'h03; le = 1; vo = 1; dodd = 8'h01; lo = 1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({m_tvalid, m_tdata, m_tlast, m_tuser, tready_even, tready_odd} !==
          {1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable: got v=%b d=%h l=%b u=%b re=%b ro=%b, required v=1 d=0f l=1 u=0 re=0 ro=0",
                 m_tvalid, m_tdata, m_tlast, m_tuser, tready_even, tready_odd);
      end
      @(posedge clk); #1;
    end
    m_tready = 1;
    @(negedge clk);
    checks++;
    if ({m_tvalid, tready_even, tready_odd} !== 3'b101) begin
      errors++;
      $display("FAIL hold_drain_load: got v=%b re=%b ro=%b, required v=1 re=0 ro=1",
               m_tvalid, tready_even, tready_odd);
    end
    @(posedge clk); #1;
    ve = 0; vo = 0;
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_next_beat: got v=%b d=%h l=%b u=%b, required v=1 d=01 l=1 u=0",
               m_tvalid, m_tdata, m_tlast, m_tuser);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, fires;
    do_reset();
    qe.push_back('{d: 8'h03, l: 1'b0}); qe.push_back('{d: 8'h05, l: 1'b0});
    qe.push_back('{d: 8'h06, l: 1'b0}); qe.push_back('{d: 8'h09, l: 1'b1});
    m_tready = 1; cyc = 0; fires = 0;
    while (fires < 2 && cyc < 20) begin
      ve = 1; de = qe[0].d; le = qe[0].l;
      @(negedge clk);
      if (tready_even) begin fires++; void'(qe.pop_front()); end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (fires != 2) begin
      errors++;
      $display("FAIL rstmid_accept: got %0d beats accepted, required 2", fires);
    end
    rst = 1; de = qe[0].d; le = qe[0].l;
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata} !== {1'b1, 8'h05}) begin
      errors++;
      $display("FAIL rstmid_beat2: got v=%b d=%h, required v=1 d=05", m_tvalid, m_tdata);
    end
    @(posedge clk); #1;
    rst = 0; ve = 0;
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, err_count, tready_even, tready_odd} !== '0) begin
      errors++;
      $display("FAIL rstmid_cleared: got v=%b d=%h l=%b u=%b e=%h re=%b ro=%b, required all 0",
               m_tvalid, m_tdata, m_tlast, m_tuser, err_count, tready_even, tready_odd);
    end
    @(posedge clk); #1;
    exp_err = 0;
    run_stream("rstmid_rest", 50, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
        int len;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) qe.push_back('{d: 8'($urandom), l: (i == len - 1)});
      end
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
        int len;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) qo.push_back('{d: 8'($urandom), l: (i == len - 1)});
      end
      run_stream("random", 2000, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arbitration();
    test_forced_tlast();
    test_parity_err();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
